// File: rtl/snn_ec_pkg.sv
// Shared definitions for the SNN layer event scheduler.
//   sched_state_e : scheduler FSM states
//   clog2_min1()  : address width helper that never returns 0
//   STATS_W       : width of the optional dispatched-spike counter
package snn_ec_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENCODE   = 3'd1,
    DISPATCH = 3'd2,
    WAIT     = 3'd3,
    ACTIV    = 3'd4,
    CAPTURE  = 3'd5,
    EMIT     = 3'd6
  } sched_state_e;

  localparam int STATS_W = 32;

  // Index width for n entries, at least 1 bit so ports never collapse to zero width.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spike_event_sched_lsb_prio_enc.sv
// Combinational lowest-set-bit priority encoder.
//   vec_i   : input vector
//   idx_o   : index of the lowest set bit (0 when vec_i is empty)
//   empty_o : high when no bit of vec_i is set
module lsb_prio_enc
  import snn_ec_pkg::*;
#(
  parameter int W  = 32,
  parameter int IW = clog2_min1(W)
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          empty_o
);

  // Scan from the top so the last hit (the lowest index) wins.
  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

  assign empty_o = (vec_i == '0);

endmodule

// File: rtl/spike_event_sched.sv
// Event scheduler for one SNN layer.
// A pre-synaptic spike vector is accepted over valid/ready, its set bits are
// serialised (lowest first) into an address queue, each address is broadcast on
// accum_en/accum_addr followed by ACCUM_CYC idle cycles, then activ_en is pulsed,
// the neurons' fire vector is captured and offered downstream over valid/ready.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high; the sender holds data stable while valid is high and not accepted.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   pre_valid/pre_ready upstream handshake, pre_spk is the spike vector
//   accum_en/accum_addr one-cycle accumulate strobe with the pre-neuron index
//   activ_en            one-cycle threshold/fire strobe
//   post_spk_in         neuron fire vector, valid the cycle after activ_en
//   post_valid/post_ready/post_spk  downstream handshake and result buffer
//   timestep            completed-timestep count (wraps)
//   spk_total           dispatched-address count, only with EVENT_SCHED_STATS_EN
//
// Build option: define EVENT_SCHED_STATS_EN to add the saturating spk_total counter.
//
// All outputs are registered from the current state, so each strobe appears one
// cycle after the state that requests it. CAPTURE is the cycle activ_en is high;
// the first EMIT cycle is when the neurons present post_spk_in, and the buffer
// loads at the end of it together with post_valid.
module spike_event_sched
  import snn_ec_pkg::*;
#(
  parameter int PRE_W     = 32,
  parameter int POST_W    = 32,
  parameter int ACCUM_CYC = 2,
  parameter int TS_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pre_valid,
  output logic                        pre_ready,
  input  logic [PRE_W-1:0]            pre_spk,
  output logic                        accum_en,
  output logic [clog2_min1(PRE_W)-1:0] accum_addr,
  output logic                        activ_en,
  input  logic [POST_W-1:0]           post_spk_in,
  output logic                        post_valid,
  input  logic                        post_ready,
  output logic [POST_W-1:0]           post_spk,
`ifdef EVENT_SCHED_STATS_EN
  output logic [STATS_W-1:0]          spk_total,
`endif
  output logic [TS_W-1:0]             timestep
);

  localparam int AW = clog2_min1(PRE_W);
  localparam int CW = $clog2(PRE_W + 1);
  localparam int WW = clog2_min1(ACCUM_CYC + 1);

  sched_state_e      state_q, state_d;
  logic [PRE_W-1:0]  vec_q, vec_d;
  logic [AW-1:0]     queue_q [PRE_W];
  logic [CW-1:0]     wr_q, wr_d;
  logic [CW-1:0]     rd_q, rd_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              q_push;

  logic              pre_ready_q, pre_ready_d;
  logic              accum_en_q, accum_en_d;
  logic [AW-1:0]     accum_addr_q, accum_addr_d;
  logic              activ_en_q, activ_en_d;
  logic              post_valid_q, post_valid_d;
  logic [POST_W-1:0] post_spk_q, post_spk_d;
  logic [TS_W-1:0]   timestep_q, timestep_d;

  logic [AW-1:0]     enc_idx;
  logic              enc_empty;

  lsb_prio_enc #(.W(PRE_W), .IW(AW)) u_enc (
    .vec_i   (vec_q),
    .idx_o   (enc_idx),
    .empty_o (enc_empty)
  );

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    wr_d         = wr_q;
    rd_d         = rd_q;
    wait_d       = wait_q;
    q_push       = 1'b0;
    accum_en_d   = 1'b0;
    accum_addr_d = accum_addr_q;
    activ_en_d   = 1'b0;
    post_valid_d = post_valid_q;
    post_spk_d   = post_spk_q;
    timestep_d   = timestep_q;

    case (state_q)
      IDLE: begin
        if (pre_valid && pre_ready_q) begin
          vec_d   = pre_spk;
          wr_d    = '0;
          rd_d    = '0;
          state_d = ENCODE;
        end
      end
      ENCODE: begin
        if (!enc_empty) begin
          q_push = 1'b1;
          // x & (x-1) clears exactly the lowest set bit.
          vec_d  = vec_q & (vec_q - PRE_W'(1));
          wr_d   = wr_q + CW'(1);
        end else if (wr_q != '0) begin
          state_d = DISPATCH;
        end else begin
          state_d = ACTIV;
        end
      end
      DISPATCH: begin
        accum_en_d   = 1'b1;
        accum_addr_d = queue_q[rd_q[AW-1:0]];
        rd_d         = rd_q + CW'(1);
        if (ACCUM_CYC > 0) begin
          state_d = WAIT;
          wait_d  = WW'(ACCUM_CYC > 0 ? ACCUM_CYC - 1 : 0);
        end else if (rd_d == wr_q) begin
          state_d = ACTIV;
        end else begin
          state_d = DISPATCH;
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          state_d = (rd_q == wr_q) ? ACTIV : DISPATCH;
        end else begin
          wait_d = wait_q - WW'(1);
        end
      end
      ACTIV: begin
        activ_en_d = 1'b1;
        state_d    = CAPTURE;
      end
      CAPTURE: begin
        state_d = EMIT;
      end
      EMIT: begin
        if (!post_valid_q) begin
          post_valid_d = 1'b1;
          post_spk_d   = post_spk_in;
        end else if (post_ready) begin
          post_valid_d = 1'b0;
          timestep_d   = timestep_q + TS_W'(1);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pre_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      wait_q       <= '0;
      pre_ready_q  <= 1'b1;
      accum_en_q   <= 1'b0;
      accum_addr_q <= '0;
      activ_en_q   <= 1'b0;
      post_valid_q <= 1'b0;
      post_spk_q   <= '0;
      timestep_q   <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      wait_q       <= wait_d;
      pre_ready_q  <= pre_ready_d;
      accum_en_q   <= accum_en_d;
      accum_addr_q <= accum_addr_d;
      activ_en_q   <= activ_en_d;
      post_valid_q <= post_valid_d;
      post_spk_q   <= post_spk_d;
      timestep_q   <= timestep_d;
    end
  end

  // Queue depth equals PRE_W, so a full vector always fits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PRE_W; i++) queue_q[i] <= '0;
    end else if (q_push) begin
      queue_q[wr_q[AW-1:0]] <= enc_idx;
    end
  end

`ifdef EVENT_SCHED_STATS_EN
  logic [STATS_W-1:0] spk_total_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_total_q <= '0;
    end else if (state_q == DISPATCH && spk_total_q != '1) begin
      spk_total_q <= spk_total_q + STATS_W'(1);
    end
  end

  assign spk_total = spk_total_q;
`endif

  assign pre_ready  = pre_ready_q;
  assign accum_en   = accum_en_q;
  assign accum_addr = accum_addr_q;
  assign activ_en   = activ_en_q;
  assign post_valid = post_valid_q;
  assign post_spk   = post_spk_q;
  assign timestep   = timestep_q;

endmodule

// File: tb/tb_spike_event_sched.sv
// Directed bench for spike_event_sched.
// dut_a: ACCUM_CYC=2, TS_W=16. dut_b: ACCUM_CYC=0, TS_W=2 (back-to-back dispatch, wrap).
// Expected addresses/edges come from the bit pattern of each vector and
// N = K+4+K*(1+A); edges are counted from the accepting edge (edge 0).
module tb_spike_event_sched;

  logic clk;
  logic rst_n;

  logic        pre_valid   [2];
  logic [31:0] pre_spk     [2];
  logic        pre_ready   [2];
  logic        accum_en    [2];
  logic [4:0]  accum_addr  [2];
  logic        activ_en    [2];
  logic [31:0] post_spk_in [2];
  logic        post_valid  [2];
  logic        post_ready  [2];
  logic [31:0] post_spk    [2];
  logic [15:0] ts_a;
  logic [1:0]  ts_b;
`ifdef EVENT_SCHED_STATS_EN
  logic [31:0] spk_total_a;
  logic [31:0] spk_total_b;
`endif

  int          n_checks;
  int          n_fail;
  logic [4:0]  exp_q[$];
  int          edge_q[$];
  logic [31:0] ts_model [2];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  spike_event_sched #(.PRE_W(32), .POST_W(32), .ACCUM_CYC(2), .TS_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .pre_valid(pre_valid[0]), .pre_ready(pre_ready[0]), .pre_spk(pre_spk[0]),
    .accum_en(accum_en[0]), .accum_addr(accum_addr[0]), .activ_en(activ_en[0]),
    .post_spk_in(post_spk_in[0]), .post_valid(post_valid[0]),
    .post_ready(post_ready[0]), .post_spk(post_spk[0]),
`ifdef EVENT_SCHED_STATS_EN
    .spk_total(spk_total_a),
`endif
    .timestep(ts_a)
  );

  spike_event_sched #(.PRE_W(32), .POST_W(32), .ACCUM_CYC(0), .TS_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .pre_valid(pre_valid[1]), .pre_ready(pre_ready[1]), .pre_spk(pre_spk[1]),
    .accum_en(accum_en[1]), .accum_addr(accum_addr[1]), .activ_en(activ_en[1]),
    .post_spk_in(post_spk_in[1]), .post_valid(post_valid[1]),
    .post_ready(post_ready[1]), .post_spk(post_spk[1]),
`ifdef EVENT_SCHED_STATS_EN
    .spk_total(spk_total_b),
`endif
    .timestep(ts_b)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_ts(input int sel);
    return (sel == 1) ? {30'd0, ts_b} : {16'd0, ts_a};
  endfunction

  function automatic logic [31:0] ts_mask(input int sel);
    return (sel == 1) ? 32'h3 : 32'hFFFF;
  endfunction

  task automatic check_idle_outputs(input int sel, input logic [31:0] exp_ts);
    check("rst_pre_ready",  32'(pre_ready[sel]),  32'd1);
    check("rst_accum_en",   32'(accum_en[sel]),   32'd0);
    check("rst_accum_addr", 32'(accum_addr[sel]), 32'd0);
    check("rst_activ_en",   32'(activ_en[sel]),   32'd0);
    check("rst_post_valid", 32'(post_valid[sel]), 32'd0);
    check("rst_post_spk",   post_spk[sel],        32'd0);
    check("rst_timestep",   get_ts(sel),          exp_ts);
  endtask

  // ---------------- driver ----------------
  // One full timestep on DUT 'sel'. With abort set, returns right after the
  // first accum_en is observed (used to reset mid-dispatch).
  task automatic run_step(input int sel, input logic [31:0] vec, input int acyc,
                          input int hold, input logic [31:0] pat, input bit abort);
    int k;
    int n_exp;
    int pulses;
    int act_cnt;
    int pv_edge;
    bit act_prev;
    logic [31:0] ts_before;

    exp_q.delete();
    edge_q.delete();
    for (int i = 0; i < 32; i++) if (vec[i]) exp_q.push_back(5'(i));
    k = exp_q.size();
    for (int j = 0; j < k; j++) edge_q.push_back(k + 2 + j * (1 + acyc));
    n_exp = k + 4 + k * (1 + acyc);

    for (int w = 0; w < 50 && !pre_ready[sel]; w++) begin
      @(posedge clk); #1;
    end
    check("pre_ready_idle", 32'(pre_ready[sel]), 32'd1);
    ts_before = get_ts(sel);

    pre_valid[sel] = 1'b1;
    pre_spk[sel]   = vec;
    @(posedge clk); #1;                    // accepting edge = edge 0
    pre_valid[sel] = 1'b0;
    pre_spk[sel]   = $urandom;
    check("pre_ready_busy", 32'(pre_ready[sel]), 32'd0);

    pulses   = 0;
    act_cnt  = 0;
    pv_edge  = -1;
    act_prev = 1'b0;
    for (int n = 1; n <= n_exp + 5 && pv_edge < 0; n++) begin
      @(posedge clk); #1;
      // Fire vector is only meaningful the cycle after activ_en.
      post_spk_in[sel] = act_prev ? pat : ~pat;
      act_prev = activ_en[sel];
      if (accum_en[sel]) begin
        pulses++;
        if (exp_q.size() > 0) begin
          check("accum_addr", 32'(accum_addr[sel]), 32'(exp_q.pop_front()));
          check("accum_edge", 32'(n), 32'(edge_q.pop_front()));
        end
        if (abort) return;
      end
      if (activ_en[sel]) begin
        act_cnt++;
        check("activ_edge", 32'(n), 32'(n_exp - 2));
      end
      if (post_valid[sel]) pv_edge = n;
    end
    check("accum_pulses", 32'(pulses), 32'(k));
    check("activ_pulses", 32'(act_cnt), 32'd1);
    check("post_valid_edge", 32'(pv_edge), 32'(n_exp));
    check("post_spk", post_spk[sel], pat);

    // Downstream stalls: result and control must hold.
    for (int h = 0; h < hold; h++) begin
      post_spk_in[sel] = $urandom;
      @(posedge clk); #1;
      check("hold_post_valid", 32'(post_valid[sel]), 32'd1);
      check("hold_post_spk",   post_spk[sel],        pat);
      check("hold_pre_ready",  32'(pre_ready[sel]),  32'd0);
      check("hold_timestep",   get_ts(sel),          ts_before);
    end

    post_ready[sel] = 1'b1;
    @(posedge clk); #1;
    post_ready[sel] = 1'b0;
    ts_model[sel] = (ts_model[sel] + 32'd1) & ts_mask(sel);
    check("post_valid_drop", 32'(post_valid[sel]), 32'd0);
    check("pre_ready_back",  32'(pre_ready[sel]),  32'd1);
    check("timestep_inc",    get_ts(sel),          ts_model[sel]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int s = 0; s < 2; s++) begin
      pre_valid[s]   = 1'b0;
      pre_spk[s]     = '0;
      post_spk_in[s] = '0;
      post_ready[s]  = 1'b0;
      ts_model[s]    = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) check_idle_outputs(s, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // dut_a: K=3 (addr 1,4,31 three cycles apart), K=5 with a 10-cycle stall, K=0.
    run_step(0, 32'h8000_0012, 2, 0,  32'hA5A5_0001, 1'b0);
    run_step(0, 32'h0000_001F, 2, 10, 32'h0F0F_1234, 1'b0);
    run_step(0, 32'h0000_0000, 2, 0,  32'h8000_0001, 1'b0);
    check("ts_after_three", get_ts(0), 32'd3);
`ifdef EVENT_SCHED_STATS_EN
    check("spk_total_8", spk_total_a, 32'd8);
`endif

    // dut_b: all 32 addresses back-to-back, result pattern all ones.
    run_step(1, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 1'b0);

    // Reset in the middle of dispatch: everything clears without waiting for a clock.
    run_step(1, 32'hFFFF_FFFF, 0, 0, 32'h1234_5678, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) check_idle_outputs(s, 32'd0);
`ifdef EVENT_SCHED_STATS_EN
    check("spk_total_rst", spk_total_a, 32'd0);
`endif
    @(posedge clk);
    #3 rst_n = 1'b1;
    ts_model[0] = '0;
    ts_model[1] = '0;
    @(posedge clk); #1;

    // Post-reset single spike: only address 0.
    run_step(0, 32'h0000_0001, 2, 0, 32'h0000_00C3, 1'b0);
`ifdef EVENT_SCHED_STATS_EN
    check("spk_total_1", spk_total_a, 32'd1);
`endif

    // 2-bit timestep wraps: five steps end at 1.
    run_step(1, 32'h0000_0003, 0, 0, 32'h0000_0011, 1'b0);
    run_step(1, 32'h0000_0000, 0, 0, 32'h0000_0022, 1'b0);
    run_step(1, 32'h8000_0000, 0, 0, 32'h0000_0033, 1'b0);
    run_step(1, 32'h0000_0010, 0, 3, 32'h0000_0044, 1'b0);
    run_step(1, 32'h0000_0005, 0, 0, 32'h0000_0055, 1'b0);
    check("ts_wrap", get_ts(1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
